// File: rtl/axi_line_arbiter.sv
// axi_line_arbiter: round-robin arbiter that turns per-port cacheline refill and
// write-back requests into AXI3 bursts on a single master port. A dirty miss runs
// its write-back (AW, W, B) to completion before the refill read (AR, R) starts.
//
// Handshake rule: every AXI channel transfers on the rising edge where valid and
// ready are both high. Once raised, a valid output stays high with stable payload
// until that edge. The ready outputs (rready, bready) are high for the whole R and
// B phases.
module axi_line_arbiter #(
    parameter int NPORT      = 3,
    parameter int LINE_WORDS = 16,
    parameter int ID_W       = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NPORT-1:0]                 req_ren,
    input  logic [NPORT-1:0]                 req_wen,
    input  logic [NPORT-1:0]                 req_single,
    input  logic [NPORT*32-1:0]              req_raddr,
    input  logic [NPORT*32-1:0]              req_waddr,
    input  logic [NPORT*4-1:0]               req_wstrb,
    input  logic [NPORT*LINE_WORDS*32-1:0]   line_old,
    output logic [NPORT*LINE_WORDS*32-1:0]   line_new,
    output logic [NPORT-1:0]                 refresh,
    output logic [ID_W-1:0]                  arid,
    output logic [31:0]                      araddr,
    output logic [3:0]                       arlen,
    output logic [2:0]                       arsize,
    output logic [1:0]                       arburst,
    output logic [1:0]                       arlock,
    output logic [3:0]                       arcache,
    output logic [2:0]                       arprot,
    output logic                             arvalid,
    input  logic                             arready,
    input  logic [ID_W-1:0]                  rid,
    input  logic [31:0]                      rdata,
    input  logic [1:0]                       rresp,
    input  logic                             rlast,
    input  logic                             rvalid,
    output logic                             rready,
    output logic [ID_W-1:0]                  awid,
    output logic [31:0]                      awaddr,
    output logic [3:0]                       awlen,
    output logic [2:0]                       awsize,
    output logic [1:0]                       awburst,
    output logic [1:0]                       awlock,
    output logic [3:0]                       awcache,
    output logic [2:0]                       awprot,
    output logic                             awvalid,
    input  logic                             awready,
    output logic [ID_W-1:0]                  wid,
    output logic [31:0]                      wdata,
    output logic [3:0]                       wstrb,
    output logic                             wlast,
    output logic                             wvalid,
    input  logic                             wready,
    input  logic [ID_W-1:0]                  bid,
    input  logic [1:0]                       bresp,
    input  logic                             bvalid,
    output logic                             bready,
    output logic [2:0]                       o_dbg_state
);

    localparam int         PW             = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam logic [3:0] FULL_LEN       = 4'(LINE_WORDS - 1);
    localparam bit         LINE_IS_SINGLE = (LINE_WORDS == 1);

    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_t;

    state_t                          r_state;
    logic [PW-1:0]                   r_ptr;
    logic [PW-1:0]                   r_gnt;
    logic                            r_ren;
    logic [31:0]                     r_raddr;
    logic [31:0]                     r_waddr;
    logic [3:0]                      r_wstrb;
    logic [3:0]                      r_len;
    logic [LINE_WORDS*32-1:0]        r_line_old;
    logic [3:0]                      r_beat;
    logic                            r_arvalid;
    logic                            r_awvalid;
    logic                            r_wvalid;
    logic                            r_bready;
    logic                            r_rready;
    logic [NPORT-1:0]                r_refresh;
    logic [NPORT*LINE_WORDS*32-1:0]  r_line_new;

    logic                            w_found;
    logic [PW-1:0]                   w_gidx;
    int                              w_best;
    int                              w_dist;
    logic                            w_sel_ren;
    logic                            w_sel_wen;
    logic                            w_sel_single;
    logic [31:0]                     w_sel_raddr;
    logic [31:0]                     w_sel_waddr;
    logic [3:0]                      w_sel_wstrb;
    logic [LINE_WORDS*32-1:0]        w_sel_line;
    logic [NPORT-1:0]                w_gnt_onehot;
    logic [31:0]                     w_wdata;
    logic                            w_unused;

    // Response ids and codes carry no information for this block.
    assign w_unused = ^{rid, rresp, bid, bresp};

    // Round-robin pick: the eligible port closest after the last granted one.
    always_comb begin
        w_found = 1'b0;
        w_gidx  = '0;
        w_best  = NPORT;
        w_dist  = 0;
        for (int i = 0; i < NPORT; i++) begin
            w_dist = i - int'(r_ptr) - 1;
            if (w_dist < 0) w_dist = w_dist + NPORT;
            if ((req_ren[i] | req_wen[i]) && (w_dist < w_best)) begin
                w_best  = w_dist;
                w_gidx  = PW'(i);
                w_found = 1'b1;
            end
        end
    end

    // Select the request fields of the winning port for latching at grant.
    always_comb begin
        w_sel_ren    = 1'b0;
        w_sel_wen    = 1'b0;
        w_sel_single = 1'b0;
        w_sel_raddr  = '0;
        w_sel_waddr  = '0;
        w_sel_wstrb  = '0;
        w_sel_line   = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (w_gidx == PW'(i)) begin
                w_sel_ren    = req_ren[i];
                w_sel_wen    = req_wen[i];
                w_sel_single = req_single[i];
                w_sel_raddr  = req_raddr[i*32 +: 32];
                w_sel_waddr  = req_waddr[i*32 +: 32];
                w_sel_wstrb  = req_wstrb[i*4 +: 4];
                w_sel_line   = line_old[i*LINE_WORDS*32 +: LINE_WORDS*32];
            end
        end
    end

    // One-hot of the granted port, and the write-back word for the current beat.
    always_comb begin
        w_gnt_onehot = '0;
        w_wdata      = '0;
        for (int i = 0; i < NPORT; i++) w_gnt_onehot[i] = (r_gnt == PW'(i));
        for (int k = 0; k < LINE_WORDS; k++) begin
            if (r_beat == 4'(k)) w_wdata = r_line_old[k*32 +: 32];
        end
    end

    // Transaction FSM with registered channel valids/readys and refill storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_gnt      <= '0;
            r_ren      <= 1'b0;
            r_raddr    <= '0;
            r_waddr    <= '0;
            r_wstrb    <= '0;
            r_len      <= '0;
            r_line_old <= '0;
            r_beat     <= '0;
            r_arvalid  <= 1'b0;
            r_awvalid  <= 1'b0;
            r_wvalid   <= 1'b0;
            r_bready   <= 1'b0;
            r_rready   <= 1'b0;
            r_refresh  <= '0;
            r_line_new <= '0;
        end else begin
            r_refresh <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_gnt      <= w_gidx;
                        r_ren      <= w_sel_ren;
                        r_raddr    <= w_sel_raddr;
                        r_waddr    <= w_sel_waddr;
                        r_line_old <= w_sel_line;
                        r_len      <= (w_sel_single || LINE_IS_SINGLE) ? 4'd0 : FULL_LEN;
                        r_wstrb    <= (w_sel_single && !LINE_IS_SINGLE) ? w_sel_wstrb : 4'hF;
                        if (w_sel_wen) begin
                            r_awvalid <= 1'b1;
                            r_state   <= S_AW;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= S_AR;
                        end
                    end
                end
                S_AW: begin
                    if (awready) begin
                        r_awvalid <= 1'b0;
                        r_wvalid  <= 1'b1;
                        r_beat    <= '0;
                        r_state   <= S_W;
                    end
                end
                S_W: begin
                    if (wready) begin
                        if (r_beat == r_len) begin
                            r_wvalid <= 1'b0;
                            r_bready <= 1'b1;
                            r_beat   <= '0;
                            r_state  <= S_B;
                        end else begin
                            r_beat <= r_beat + 4'd1;
                        end
                    end
                end
                S_B: begin
                    if (bvalid) begin
                        r_bready <= 1'b0;
                        if (r_ren) begin
                            r_arvalid <= 1'b1;
                            r_state   <= S_AR;
                        end else begin
                            r_refresh <= w_gnt_onehot;
                            r_state   <= S_DONE;
                        end
                    end
                end
                S_AR: begin
                    if (arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_beat    <= '0;
                        r_state   <= S_R;
                    end
                end
                S_R: begin
                    if (rvalid) begin
                        for (int p = 0; p < NPORT; p++) begin
                            for (int k = 0; k < LINE_WORDS; k++) begin
                                if ((r_gnt == PW'(p)) && (r_beat == 4'(k)))
                                    r_line_new[(p*LINE_WORDS+k)*32 +: 32] <= rdata;
                            end
                        end
                        if (r_beat != FULL_LEN) r_beat <= r_beat + 4'd1;
                        if (rlast) begin
                            r_rready  <= 1'b0;
                            r_beat    <= '0;
                            r_refresh <= w_gnt_onehot;
                            r_state   <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_ptr   <= r_gnt;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign line_new    = r_line_new;
    assign refresh     = r_refresh;
    assign arid        = ID_W'(r_gnt);
    assign araddr      = r_raddr;
    assign arlen       = r_len;
    assign arsize      = 3'b010;
    assign arburst     = 2'b01;
    assign arlock      = 2'b00;
    assign arcache     = 4'b0000;
    assign arprot      = 3'b000;
    assign arvalid     = r_arvalid;
    assign rready      = r_rready;
    assign awid        = ID_W'(r_gnt);
    assign awaddr      = r_waddr;
    assign awlen       = r_len;
    assign awsize      = 3'b010;
    assign awburst     = 2'b01;
    assign awlock      = 2'b00;
    assign awcache     = 4'b0000;
    assign awprot      = 3'b000;
    assign awvalid     = r_awvalid;
    assign wid         = ID_W'(r_gnt);
    assign wdata       = w_wdata;
    assign wstrb       = r_wstrb;
    assign wlast       = r_wvalid & (r_beat == r_len);
    assign wvalid      = r_wvalid;
    assign bready      = r_bready;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_axi_line_arbiter.sv
// tb_axi_line_arbiter: directed bench for axi_line_arbiter acting as the AXI slave
// and the three cache ports (defaults: 3 ports, 16-word lines, 4-bit ids).
module tb_axi_line_arbiter;

    localparam int NPORT = 3;
    localparam int LW    = 16;
    localparam int ID_W  = 4;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NPORT-1:0]          req_ren, req_wen, req_single;
    logic [NPORT*32-1:0]       req_raddr, req_waddr;
    logic [NPORT*4-1:0]        req_wstrb;
    logic [NPORT*LW*32-1:0]    line_old;
    logic [NPORT*LW*32-1:0]    line_new;
    logic [NPORT-1:0]          refresh;
    logic [ID_W-1:0]           arid, awid, wid, rid, bid;
    logic [31:0]               araddr, awaddr, rdata, wdata;
    logic [3:0]                arlen, awlen, arcache, awcache, wstrb;
    logic [2:0]                arsize, awsize, arprot, awprot, o_dbg_state;
    logic [1:0]                arburst, awburst, arlock, awlock, rresp, bresp;
    logic                      arvalid, arready, rlast, rvalid, rready;
    logic                      awvalid, awready, wlast, wvalid, wready, bvalid, bready;

    axi_line_arbiter #(.NPORT(NPORT), .LINE_WORDS(LW), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst),
        .req_ren(req_ren), .req_wen(req_wen), .req_single(req_single),
        .req_raddr(req_raddr), .req_waddr(req_waddr), .req_wstrb(req_wstrb),
        .line_old(line_old), .line_new(line_new), .refresh(refresh),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .o_dbg_state(o_dbg_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard state
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [31:0] rd_q[$];
    int          t_refresh;
    bit          mon_en = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // At most one refresh bit may be high in any cycle.
    always @(negedge clk) begin
        if (mon_en) check("refresh_onehot", {63'd0, $onehot0(refresh)}, 64'd1);
    end

    function automatic logic [31:0] word(input int p, input int k);
        return line_new[(p*LW+k)*32 +: 32];
    endfunction

    // Driver tasks
    task automatic set_line_old(input int p, input logic [31:0] base);
        for (int k = 0; k < LW; k++) line_old[(p*LW+k)*32 +: 32] = base + 32'(k);
    endtask

    task automatic serve_ar(input int delay, input logic [31:0] ea, input logic [3:0] el, input int eid);
        int t = 0;
        while (!arvalid && t < 200) begin @(negedge clk); t++; end
        if (!arvalid) begin check("ar_timeout", 0, 1); return; end
        check("araddr", araddr, ea);
        check("arlen", arlen, el);
        check("arid", arid, eid);
        check("ar_size_burst", {arsize, arburst, arlock, arcache, arprot}, {3'b010, 2'b01, 9'd0});
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            check("ar_hold", {arvalid, araddr, arlen}, {1'b1, ea, el});
        end
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        check("ar_drop", arvalid, 0);
    endtask

    task automatic serve_r(input int nbeats, input int maxgap, input bit give_last);
        for (int b = 0; b < nbeats; b++) begin
            repeat ($urandom_range(maxgap, 0)) @(negedge clk);
            check("rready", rready, 1);
            rvalid = 1'b1;
            rdata  = rd_q.pop_front();
            rlast  = give_last && (b == nbeats - 1);
            rresp  = 2'(b);
            @(negedge clk);
            rvalid = 1'b0;
            rlast  = 1'b0;
        end
    endtask

    task automatic serve_aw(input logic [31:0] ea, input logic [3:0] el, input int eid);
        int t = 0;
        while (!awvalid && t < 200) begin @(negedge clk); t++; end
        if (!awvalid) begin check("aw_timeout", 0, 1); return; end
        check("awaddr", awaddr, ea);
        check("awlen", awlen, el);
        check("awid", awid, eid);
        check("aw_size_burst", {awsize, awburst}, {3'b010, 2'b01});
        awready = 1'b1;
        @(negedge clk);
        awready = 1'b0;
        check("aw_drop", awvalid, 0);
    endtask

    task automatic serve_w(input int nbeats, input logic [3:0] es, input int eid);
        for (int b = 0; b < nbeats; b++) begin
            int t = 0;
            while (!wvalid && t < 200) begin @(negedge clk); t++; end
            if (!wvalid) begin check("w_timeout", 0, 1); return; end
            check("wdata", wdata, exp_q.pop_front());
            check("wlast", wlast, (b == nbeats - 1));
            check("wstrb", wstrb, es);
            check("wid", wid, eid);
            check("no_ar_during_w", arvalid, 0);
            wready = 1'b1;
            @(negedge clk);
            wready = 1'b0;
        end
        check("w_drop", wvalid, 0);
    endtask

    task automatic serve_b();
        int t = 0;
        while (!bready && t < 200) begin @(negedge clk); t++; end
        if (!bready) begin check("b_timeout", 0, 1); return; end
        check("no_ar_before_b", arvalid, 0);
        bvalid = 1'b1;
        bresp  = 2'b10;
        @(negedge clk);
        bvalid = 1'b0;
    endtask

    task automatic wait_refresh(input logic [NPORT-1:0] exp);
        int t = 0;
        while (refresh == '0 && t < 200) begin @(negedge clk); t++; end
        check("refresh", refresh, exp);
        t_refresh = cyc;
        req_ren   = req_ren & ~exp;
        req_wen   = req_wen & ~exp;
        @(negedge clk);
        check("refresh_pulse", refresh, 0);
    endtask

    task automatic check_line(input int p, input string tag);
        for (int k = 0; k < LW; k++) check(tag, word(p, k), exp_q.pop_front());
    endtask

    int t0;

    initial begin
        rst = 1'b1;
        req_ren = '0; req_wen = '0; req_single = '0;
        req_raddr = '0; req_waddr = '0; req_wstrb = '0; line_old = '0;
        arready = 1'b0; awready = 1'b0; wready = 1'b0;
        rvalid = 1'b0; rlast = 1'b0; rdata = '0; rid = '0; rresp = '0;
        bvalid = 1'b0; bid = '0; bresp = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_valids", {arvalid, awvalid, wvalid, rready, bready}, 0);
        check("rst_refresh", refresh, 0);
        check("rst_line_new", {63'd0, |line_new}, 0);
        check("rst_addr_len_id", {araddr, awaddr}, 0);
        check("rst_len_id", {arlen, awlen, arid, awid}, 0);
        check("rst_state", o_dbg_state, 0);
        rst = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;

        // Line refill on port 0, zero-wait slave, latency check
        req_raddr[0*32 +: 32] = 32'h1FC0_0000;
        req_ren[0] = 1'b1;
        t0 = cyc;
        for (int k = 0; k < LW; k++) begin rd_q.push_back(32'(k)); exp_q.push_back(32'(k)); end
        serve_ar(0, 32'h1FC0_0000, 4'd15, 0);
        serve_r(LW, 0, 1'b1);
        wait_refresh(3'b001);
        check("refill_latency", t_refresh - t0, LW + 2);
        check_line(0, "refill_p0");
        check("p1_untouched", word(1, 0), 0);
        check("p2_untouched", word(2, 15), 0);

        // Dirty miss on port 1: write-back then refill
        req_waddr[1*32 +: 32] = 32'h0000_1000;
        req_raddr[1*32 +: 32] = 32'h0000_2000;
        set_line_old(1, 32'hA0);
        req_wen[1] = 1'b1;
        req_ren[1] = 1'b1;
        for (int k = 0; k < LW; k++) exp_q.push_back(32'hA0 + 32'(k));
        serve_aw(32'h0000_1000, 4'd15, 1);
        serve_w(LW, 4'hF, 1);
        serve_b();
        for (int k = 0; k < LW; k++) begin
            rd_q.push_back(32'h100 + 32'(k));
            exp_q.push_back(32'h100 + 32'(k));
        end
        serve_ar(0, 32'h0000_2000, 4'd15, 1);
        serve_r(LW, 0, 1'b1);
        wait_refresh(3'b010);
        check_line(1, "refill_p1");
        check("p0_held", word(0, 3), 32'd3);

        // Single write on port 2: one beat, no read
        req_waddr[2*32 +: 32] = 32'hBFAF_F000;
        req_wstrb[2*4 +: 4]   = 4'b0011;
        line_old[(2*LW+0)*32 +: 32] = 32'hDEAD_BEEF;
        line_old[(2*LW+1)*32 +: 32] = 32'h1111_2222;
        req_single[2] = 1'b1;
        req_wen[2]    = 1'b1;
        exp_q.push_back(32'hDEAD_BEEF);
        serve_aw(32'hBFAF_F000, 4'd0, 2);
        serve_w(1, 4'b0011, 2);
        serve_b();
        check("single_no_ar", arvalid, 0);
        wait_refresh(3'b100);
        req_single = '0;

        // Contention: all three ports together, twice
        for (int p = 0; p < NPORT; p++) req_raddr[p*32 +: 32] = 32'h1000_0000 + 32'(p * 256);
        for (int r = 0; r < 2; r++) begin
            req_ren = 3'b111;
            for (int j = 0; j < NPORT; j++) begin
                for (int k = 0; k < LW; k++) begin
                    rd_q.push_back(32'(r * 16777216 + j * 65536 + k));
                    exp_q.push_back(32'(r * 16777216 + j * 65536 + k));
                end
                serve_ar(0, 32'h1000_0000 + 32'(j * 256), 4'd15, j);
                serve_r(LW, 0, 1'b1);
                wait_refresh(3'(1 << j));
                check_line(j, "contend_line");
            end
        end

        // Backpressure on AR and R
        req_raddr[0*32 +: 32] = 32'h8000_0040;
        for (int it = 0; it < 2; it++) begin
            req_ren[0] = 1'b1;
            for (int k = 0; k < LW; k++) begin
                logic [31:0] v;
                v = $urandom;
                rd_q.push_back(v);
                exp_q.push_back(v);
            end
            serve_ar($urandom_range(5, 0), 32'h8000_0040, 4'd15, 0);
            serve_r(LW, 5, 1'b1);
            wait_refresh(3'b001);
            check_line(0, "bp_line");
        end

        // Reset in the middle of a refill (before beat 7)
        req_raddr[1*32 +: 32] = 32'h0000_3000;
        req_ren[1] = 1'b1;
        for (int k = 0; k < 7; k++) rd_q.push_back(32'h7700 + 32'(k));
        serve_ar(0, 32'h0000_3000, 4'd15, 1);
        serve_r(7, 0, 1'b0);
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_mid_rready", rready, 0);
        check("rst_mid_arvalid", arvalid, 0);
        check("rst_mid_refresh", refresh, 0);
        check("rst_mid_line", {63'd0, |line_new}, 0);
        check("rst_mid_state", o_dbg_state, 0);
        req_ren = '0;
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_stale_refresh", {refresh, arvalid, awvalid}, 0);
        end

        // Fresh single read on port 2 after reset
        req_raddr[2*32 +: 32] = 32'h0000_4000;
        req_single[2] = 1'b1;
        req_ren[2]    = 1'b1;
        rd_q.push_back(32'h55AA_1234);
        serve_ar(0, 32'h0000_4000, 4'd0, 2);
        serve_r(1, 0, 1'b1);
        wait_refresh(3'b100);
        check("post_rst_word0", word(2, 0), 32'h55AA_1234);
        check("post_rst_word1", word(2, 1), 0);
        check("post_rst_p1", word(1, 0), 0);
        mon_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_line_arbiter.md
AXI_LINE_ARBITER -- requirements
Module: axi_line_arbiter

Interface
REQ-001 Parameter NPORT, default 3: number of requesting ports (icache, dcache, uncache); legal range 1..8.
REQ-002 Parameter LINE_WORDS, default 16: 32-bit words per cacheline; power of two, 1..16 (AXI3 4-bit len).
REQ-003 Parameter ID_W, default 4: width of arid/awid.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 req_ren  in  NPORT  per-port read (refill) request, level, held until refresh.
REQ-007 req_wen  in  NPORT  per-port write-back request, level, held until refresh.
REQ-008 req_single  in  NPORT  per-port single-word (uncached) mode; sampled at grant.
REQ-009 req_raddr, req_waddr  in  NPORT*32 each  per-port read and write addresses, port i at bits [32i+31:32i].
REQ-010 req_wstrb  in  NPORT*4  byte strobes, single mode only; line mode always drives 4'b1111.
REQ-011 line_old  in  NPORT*LINE_WORDS*32  write-back data, word k at bits [32k+31:32k] within the port slice.
REQ-012 line_new  out  NPORT*LINE_WORDS*32  refill data, same layout.
REQ-013 refresh  out  NPORT  one-cycle completion pulse for the granted port.
REQ-014 AXI3 master ports: ar*, r*, aw*, w*, b*. Widths are standard, with ids ID_W.

Function
REQ-015 FSM states: IDLE, AW, W, B, AR, R, DONE.
REQ-016 IDLE: a port is eligible if req_ren|req_wen. Round-robin grant starts from the port after the last granted port (pointer reset = port 0). Grant, addresses, single, wstrb and line_old are latched at grant.
REQ-017 Exit from IDLE: go to AW if latched wen, else AR.
REQ-018 AW: awvalid=1, held with stable fields until awready. Then go to W.
REQ-019 W: wvalid=1, beat k carries latched word k. wlast on the final beat. Advance on wready. After the final beat, go to B.
REQ-020 B: bready=1. On bvalid, go to AR if latched ren, else DONE.
REQ-021 AR: arvalid=1, held until arready. Then go to R.
REQ-022 R: rready=1. Each rvalid writes rdata into word k of the granted port's line_new slice, then k increments, saturating at LINE_WORDS-1. rvalid&rlast goes to DONE.
REQ-023 DONE: refresh[grant]=1 for exactly one cycle. Pointer updates to the granted port. Go to IDLE. No new grant in the same cycle.
REQ-024 Burst length:
- line mode: ar/awlen = LINE_WORDS-1.
- single mode: len = 0, single beat on word 0.
- LINE_WORDS=1 behaves as single mode with wstrb 4'b1111.
REQ-025 Fixed fields:
- arsize/awsize = 3'b010; arburst/awburst = 2'b01.
- lock/cache/prot = 0.
- arid = awid = wid = granted port index, zero-extended.
REQ-026 rid, bid, rresp, bresp are ignored. Data is forwarded regardless of response.
REQ-027 Write-before-read for the same grant: victim write-back fully completes (bvalid) before ar issues.
REQ-028 A request deasserted mid-transaction does not abort it. The transaction completes and refresh still pulses.
REQ-029 line_new slices of non-granted ports are never modified. Each slice holds its value until overwritten.
REQ-030 Latency with zero-wait slave, line-mode read only: grant cycle, AR 1 cycle, then LINE_WORDS beats, then refresh on the next cycle.

Reset
REQ-031 While rst=1, asynchronously:
- FSM = IDLE, rr pointer = 0, beat counter = 0.
- all valid/ready outputs = 0, refresh = 0, line_new = 0.
- address, len and id outputs = 0.
REQ-032 Reset mid-burst drops all valids immediately. After release, the block resumes from IDLE with no refresh for the aborted transaction.

Verification
REQ-033 Line refill, LINE_WORDS=16: port 0 ren, raddr 0x1FC0_0000, slave returns 0..15 -> araddr 0x1FC0_0000, arlen 15, line_new word k = k, refresh[0] one pulse.
REQ-034 Dirty miss: port 1 wen+ren, waddr 0x0000_1000, line_old word k = 0xA0+k -> 16 W beats with wlast on beat 15, then bvalid, then AR, then refresh[1].
REQ-035 Single write: port 2 single, wen, wstrb 4'b0011, waddr 0xBFAF_F000 -> awlen 0, one beat with wlast=1 and wstrb 0011, no AR, refresh[2].
REQ-036 Contention: ports 0, 1, 2 request together, repeated twice -> grant order 0,1,2,0,1,2. Never two refresh bits in one cycle.
REQ-037 Backpressure: arready and rvalid each low for random 0-5 cycles -> arvalid/araddr stable while waiting, data correct.
REQ-038 Reset mid-R (beat 7) -> rready/arvalid 0 during reset. Next request completes normally with no stale refresh.
